// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and width helpers.
package reset_sequencer_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int ch_width(input int n_ch);
    return (n_ch < 2) ? 1 : clog2(n_ch);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: after lock, wait INIT_DELAY cycles, then pulse (or release)
// each downstream reset in index order with optional stagger; lock loss and trig restart it.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int CNT_WIDTH  = 32,
  parameter  int INIT_DELAY = 1000000,
  parameter  int PULSE_LEN  = 30,
  parameter  int STAGGER    = 16,
  parameter  int HOLD_MODE  = 0,
  localparam int CH_W       = ch_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst_orig,
  input  logic            lock_in,
  input  logic            trig,
  output logic [N_CH-1:0] rst_out,
  output logic            busy,
  output logic            done,
  output logic [CH_W-1:0] cur_ch
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LAST  = CNT_WIDTH'(INIT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST   = CNT_WIDTH'(STAGGER - 1);
  localparam logic [CH_W-1:0]      LAST_CH    = CH_W'(N_CH - 1);
  // Idle/wait level of every channel: asserted in hold mode, quiet in pulse mode.
  localparam logic [N_CH-1:0]      RST_IDLE   = {N_CH{HOLD_MODE != 0}};

  logic                 lock_s;
  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic                 enter;
  logic [N_CH-1:0]      rst_out_q, rst_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CH_W-1:0]      cur_ch_q, cur_ch_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst_orig),
    .d   (lock_in),
    .q   (lock_s)
  );

  // Next-state decode; 'enter' flags any state entry, including PULSE->PULSE and WAIT->WAIT.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    state_d = state_q;
    ch_d    = ch_q;
    enter   = 1'b0;
    if (state_q == S_IDLE) begin
      if (lock_s) begin
        state_d = S_WAIT;
        ch_d    = '0;
        enter   = 1'b1;
      end
    end else if (!lock_s) begin
      state_d = S_IDLE;
      ch_d    = '0;
      enter   = 1'b1;
    end else if (trig) begin
      state_d = S_WAIT;
      ch_d    = '0;
      enter   = 1'b1;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_d = S_PULSE;
            enter   = 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            enter = 1'b1;
            if (ch_q == LAST_CH) begin
              state_d = S_DONE;
            end else if (STAGGER > 0) begin
              state_d = S_GAP;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_PULSE;
            ch_d    = ch_q + 1'b1;
            enter   = 1'b1;
          end
        end
        S_DONE: ;
        default: begin
          state_d = S_IDLE;
          ch_d    = '0;
          enter   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (enter) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT || state_q == S_PULSE || state_q == S_GAP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_comb begin
    rst_out_d = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    cur_ch_d  = '0;
    case (state_d)
      S_IDLE: rst_out_d = RST_IDLE;
      S_WAIT: begin
        rst_out_d = RST_IDLE;
        busy_d    = 1'b1;
      end
      S_PULSE, S_GAP: begin
        busy_d   = 1'b1;
        cur_ch_d = ch_d;
        for (int k = 0; k < N_CH; k++) begin
          if (HOLD_MODE != 0) begin
            rst_out_d[k] = (CH_W'(k) > ch_d) || (CH_W'(k) == ch_d && state_d == S_PULSE);
          end else begin
            rst_out_d[k] = (CH_W'(k) == ch_d) && (state_d == S_PULSE);
          end
        end
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_orig) begin
    if (rst_orig) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst_orig) begin
    if (rst_orig) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  always_ff @(posedge clk or posedge rst_orig) begin
    if (rst_orig) ch_q <= '0;
    else          ch_q <= ch_d;
  end

  always_ff @(posedge clk or posedge rst_orig) begin
    if (rst_orig) begin
      rst_out_q <= RST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_ch_q  <= '0;
    end else begin
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cur_ch_q  <= cur_ch_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_ch  = cur_ch_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations share stimulus; a timeline model feeds a
// per-instance expectation queue that a negedge monitor drains and compares.
module tb_reset_sequencer;

  localparam int NCH = 3;
  localparam int ID  = 8;

  logic clk;
  logic rst_orig;
  logic lock_in;
  logic trig;

  logic [NCH-1:0] rst_out0, rst_out1, rst_out2;
  logic           busy0, busy1, busy2;
  logic           done0, done1, done2;
  logic [1:0]     cur_ch0, cur_ch1, cur_ch2;

  reset_sequencer #(.N_CH(NCH), .CNT_WIDTH(8), .INIT_DELAY(ID), .PULSE_LEN(3), .STAGGER(2),
                    .HOLD_MODE(0)) dut0 (
    .clk(clk), .rst_orig(rst_orig), .lock_in(lock_in), .trig(trig),
    .rst_out(rst_out0), .busy(busy0), .done(done0), .cur_ch(cur_ch0));

  reset_sequencer #(.N_CH(NCH), .CNT_WIDTH(8), .INIT_DELAY(ID), .PULSE_LEN(3), .STAGGER(2),
                    .HOLD_MODE(1)) dut1 (
    .clk(clk), .rst_orig(rst_orig), .lock_in(lock_in), .trig(trig),
    .rst_out(rst_out1), .busy(busy1), .done(done1), .cur_ch(cur_ch1));

  reset_sequencer #(.N_CH(NCH), .CNT_WIDTH(8), .INIT_DELAY(ID), .PULSE_LEN(1), .STAGGER(0),
                    .HOLD_MODE(0)) dut2 (
    .clk(clk), .rst_orig(rst_orig), .lock_in(lock_in), .trig(trig),
    .rst_out(rst_out2), .busy(busy2), .done(done2), .cur_ch(cur_ch2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got rst_out=%b busy=%b done=%b cur_ch=%0d, want rst_out=%b busy=%b done=%b cur_ch=%0d",
               name, $time, act[6:4], act[3], act[2], act[1:0], exp[6:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Expected outputs as a function of elapsed cycles t since WAIT entry (t=0 is the first
  // WAIT cycle); packed {rst_out, busy, done, cur_ch}.
  function automatic logic [6:0] model_out(input int d, input bit active, input int t);
    int pl, st, total, u, k, r;
    bit hold;
    logic [2:0] ro;
    pl   = (d == 2) ? 1 : 3;
    st   = (d == 2) ? 0 : 2;
    hold = (d == 1);
    if (!active) return {hold ? 3'b111 : 3'b000, 4'b0000};
    if (t < ID)  return {hold ? 3'b111 : 3'b000, 1'b1, 1'b0, 2'd0};
    u     = t - ID;
    total = NCH * pl + (NCH - 1) * st;
    if (u >= total) return {3'b000, 1'b0, 1'b1, 2'd0};
    k  = u / (pl + st);
    r  = u % (pl + st);
    ro = 3'b000;
    for (int j = 0; j < NCH; j++) begin
      if (hold ? (j > k || (j == k && r < pl)) : (j == k && r < pl)) ro[j] = 1'b1;
    end
    return {ro, 1'b1, 1'b0, 2'(k)};
  endfunction

  logic [6:0] q0[$];
  logic [6:0] q1[$];
  logic [6:0] q2[$];

  bit m_active = 1'b0;
  int m_t      = 0;
  bit m_l1     = 1'b0;
  bit m_l2     = 1'b0;

  // Reference model: advances once per clock edge, or collapses to reset immediately.
  initial begin
    bit ls;
    forever begin
      @(posedge clk or posedge rst_orig);
      if (rst_orig) begin
        m_active = 1'b0;
        m_t      = 0;
        m_l1     = 1'b0;
        m_l2     = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
      end else begin
        ls   = m_l2;
        m_l2 = m_l1;
        m_l1 = lock_in;
        if (!m_active) begin
          if (ls) begin
            m_active = 1'b1;
            m_t      = 0;
          end
        end else if (!ls) begin
          m_active = 1'b0;
        end else if (trig) begin
          m_t = 0;
        end else begin
          m_t++;
        end
      end
      q0.push_back(model_out(0, m_active, m_t));
      q1.push_back(model_out(1, m_active, m_t));
      q2.push_back(model_out(2, m_active, m_t));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (q0.size() > 0) check("dut0_pulse", {rst_out0, busy0, done0, cur_ch0}, q0.pop_front());
      if (q1.size() > 0) check("dut1_hold",  {rst_out1, busy1, done1, cur_ch1}, q1.pop_front());
      if (q2.size() > 0) check("dut2_nogap", {rst_out2, busy2, done2, cur_ch2}, q2.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    cyc(1);
    trig = 1'b0;
  endtask

  initial begin
    rst_orig = 1'b1;
    lock_in  = 1'b0;
    trig     = 1'b0;
    cyc(3);
    rst_orig = 1'b0;
    cyc(2);

    // Power-up sequence in all three configurations.
    lock_in = 1'b1;
    cyc(40);

    // Restart from DONE, then drop lock in the middle of the ch1 pulse and regain it.
    pulse_trig();
    cyc(13);
    lock_in = 1'b0;
    cyc(6);
    lock_in = 1'b1;
    cyc(35);

    // trig in DONE; then trig on the same edge that lock loss is first seen.
    pulse_trig();
    cyc(30);
    lock_in = 1'b0;
    cyc(2);
    pulse_trig();
    lock_in = 1'b1;
    cyc(30);

    // Asynchronous reset in the first gap of dut0, between clock edges.
    pulse_trig();
    cyc(11);
    rst_orig = 1'b1;
    #1;
    check("async_rst_dut0", {rst_out0, busy0, done0, cur_ch0}, 7'b000_0_0_00);
    check("async_rst_dut1", {rst_out1, busy1, done1, cur_ch1}, 7'b111_0_0_00);
    check("async_rst_dut2", {rst_out2, busy2, done2, cur_ch2}, 7'b000_0_0_00);
    cyc(2);
    rst_orig = 1'b0;
    cyc(40);

    // Randomised lock toggling, software restarts and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) < 3) lock_in = ~lock_in;
      trig     = ($urandom_range(0, 29) == 0);
      rst_orig = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    trig     = 1'b0;
    rst_orig = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
